i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 32 +++
 rtl/i2c_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C arbiter: FSM state encoding, default sizing
// constants, bus field widths and a small wrap-around increment helper.
package i2c_arb_pkg;

   localparam int DEF_NREQ           = 4;
   localparam int DEF_TIMEOUT_CYCLES = 200_000;
   localparam int ADDR_W             = 7;
   localparam int DATA_W             = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } arb_state_e;

   // Next round-robin start index after the given requester, wrapping at n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans the request vector starting at
// rr_ptr, ascending with wrap, and reports the first active index.
module rr_picker #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] rr_ptr,
   output logic [$clog2(NREQ)-1:0] winner,
   output logic                    valid
);

   localparam int IDW = $clog2(NREQ);

   int unsigned idx;
   logic        found;

   // Walk the requesters from the pointer onward and keep the first hit.
   always_comb begin
      winner = '0;
      valid  = |req;
      found  = 1'b0;
      idx    = 32'd0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (32'(rr_ptr) + 32'(i)) % 32'(NREQ);
         if (!found && req[idx]) begin
            winner = IDW'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C master between NREQ requesters.
// One transaction at a time: grant, issue a single m_newd strobe, wait for
// m_done, return a one-cycle response, then pass through IDLE again.
// Optional WAIT_DONE watchdog is compiled in with I2C_ARBITER_TIMEOUT_EN.
module i2c_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NREQ           = DEF_NREQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ-1:0]          req_op,
   input  logic [NREQ*DATA_W-1:0]   req_din,
   output logic [NREQ-1:0]          gnt,
   output logic                     rsp_valid,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [DATA_W-1:0]        rsp_dout,
   output logic                     rsp_ack_err,
   output logic                     rsp_timeout,
   output logic                     m_newd,
   output logic [ADDR_W-1:0]        m_addr,
   output logic                     m_op,
   output logic [DATA_W-1:0]        m_din,
   input  logic                     m_busy,
   input  logic                     m_done,
   input  logic [DATA_W-1:0]        m_dout,
   input  logic                     m_ack_err
);

   localparam int IDW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("i2c_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES positive");
   end

   arb_state_e          state_q, state_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [IDW-1:0]      winner_q, winner_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]      rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_dout_q, rsp_dout_d;
   logic                rsp_ack_err_q, rsp_ack_err_d;
   logic                m_newd_q, m_newd_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic                m_op_q, m_op_d;
   logic [DATA_W-1:0]   m_din_q, m_din_d;

   logic [IDW-1:0]      pick_idx;
   logic                pick_valid;
   int unsigned         sel;
   logic                timeout_hit;

   rr_picker #(.NREQ(NREQ)) u_rr_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   assign sel = 32'(pick_idx);

`ifdef I2C_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;

   // Watchdog restarts as WAIT_DONE is entered and counts every waiting cycle.
   always_comb begin
      wd_cnt_d      = wd_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
      if (state_q == ISSUE) begin
         wd_cnt_d = '0;
      end else if (state_q == WAIT_DONE) begin
         wd_cnt_d = wd_cnt_q + CNT_W'(1);
         if (m_done) begin
            rsp_timeout_d = 1'b0;
         end else if (timeout_hit) begin
            rsp_timeout_d = 1'b1;
         end
      end
   end

   assign timeout_hit = (state_q == WAIT_DONE) && !m_done &&
                        (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog and timeout flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q      <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign rsp_timeout = rsp_timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one transaction per pass, always returning to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (pick_valid && !m_busy) state_d = ISSUE;
         ISSUE:     state_d = WAIT_DONE;
         WAIT_DONE: if (m_done || timeout_hit) state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Output/datapath logic: latch the winner's command, strobe it, capture the result.
   always_comb begin
      gnt_d         = gnt_q;
      winner_d      = winner_q;
      rr_ptr_d      = rr_ptr_q;
      rsp_valid_d   = 1'b0;
      rsp_id_d      = rsp_id_q;
      rsp_dout_d    = rsp_dout_q;
      rsp_ack_err_d = rsp_ack_err_q;
      m_newd_d      = 1'b0;
      m_addr_d      = m_addr_q;
      m_op_d        = m_op_q;
      m_din_d       = m_din_q;
      case (state_q)
         IDLE: begin
            if (pick_valid && !m_busy) begin
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               winner_d        = pick_idx;
               m_addr_d        = req_addr[sel*ADDR_W +: ADDR_W];
               m_op_d          = req_op[sel];
               m_din_d         = req_din[sel*DATA_W +: DATA_W];
            end
         end
         ISSUE: begin
            m_newd_d = 1'b1;
         end
         WAIT_DONE: begin
            if (m_done) begin
               rsp_valid_d   = 1'b1;
               rsp_id_d      = winner_q;
               rsp_dout_d    = m_op_q ? m_dout : '0;
               rsp_ack_err_d = m_ack_err;
            end else if (timeout_hit) begin
               rsp_valid_d   = 1'b1;
               rsp_id_d      = winner_q;
               rsp_dout_d    = '0;
               rsp_ack_err_d = 1'b1;
            end
         end
         RESP: begin
            gnt_d    = '0;
            rr_ptr_d = IDW'(wrap_inc(32'(winner_q), NREQ));
         end
         default: ;
      endcase
   end

   // Datapath and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q         <= '0;
         winner_q      <= '0;
         rr_ptr_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_dout_q    <= '0;
         rsp_ack_err_q <= 1'b0;
         m_newd_q      <= 1'b0;
         m_addr_q      <= '0;
         m_op_q        <= 1'b0;
         m_din_q       <= '0;
      end else begin
         gnt_q         <= gnt_d;
         winner_q      <= winner_d;
         rr_ptr_q      <= rr_ptr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_dout_q    <= rsp_dout_d;
         rsp_ack_err_q <= rsp_ack_err_d;
         m_newd_q      <= m_newd_d;
         m_addr_q      <= m_addr_d;
         m_op_q        <= m_op_d;
         m_din_q       <= m_din_d;
      end
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_dout    = rsp_dout_q;
   assign rsp_ack_err = rsp_ack_err_q;
   assign m_newd      = m_newd_q;
   assign m_addr      = m_addr_q;
   assign m_op        = m_op_q;
   assign m_din       = m_din_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter. Plays the I2C master from the bench,
// predicts grants with a rotating-priority model and checks every response.
// The watchdog scenario is built only when I2C_ARBITER_TIMEOUT_EN is defined.
module tb_i2c_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 50;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ*7-1:0]   req_addr;
   logic [NREQ-1:0]     req_op;
   logic [NREQ*8-1:0]   req_din;
   logic [NREQ-1:0]     gnt;
   logic                rsp_valid;
   logic [1:0]          rsp_id;
   logic [7:0]          rsp_dout;
   logic                rsp_ack_err;
   logic                rsp_timeout;
   logic                m_newd;
   logic [6:0]          m_addr;
   logic                m_op;
   logic [7:0]          m_din;
   logic                m_busy;
   logic                m_done;
   logic [7:0]          m_dout;
   logic                m_ack_err;

   int checkCount = 0;
   int passCount  = 0;
   int rrPtr      = 0;

   logic [6:0] addrArr[NREQ];
   logic       opArr[NREQ];
   logic [7:0] dinArr[NREQ];

   i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_addr    (req_addr),
      .req_op      (req_op),
      .req_din     (req_din),
      .gnt         (gnt),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_dout    (rsp_dout),
      .rsp_ack_err (rsp_ack_err),
      .rsp_timeout (rsp_timeout),
      .m_newd      (m_newd),
      .m_addr      (m_addr),
      .m_op        (m_op),
      .m_din       (m_din),
      .m_busy      (m_busy),
      .m_done      (m_done),
      .m_dout      (m_dout),
      .m_ack_err   (m_ack_err)
   );

   always #5 clk = ~clk;

   // Compare one observed value with its expected value and tally the result.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pack the per-requester fields onto the request buses and raise the request mask.
   task automatic applyStimulus(input logic [NREQ-1:0] mask);
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*7 +: 7] = addrArr[i];
         req_op[i]          = opArr[i];
         req_din[i*8 +: 8]  = dinArr[i];
      end
      req = mask;
   endtask

   // Rotating priority: the first active requester at or after the pointer wins.
   function automatic int pickWinner(input logic [NREQ-1:0] mask, input int ptr);
      int order[$];
      for (int k = 0; k < NREQ; k++) order.push_back((ptr + k) % NREQ);
      foreach (order[k]) if (mask[order[k]]) return order[k];
      return -1;
   endfunction

   task automatic randomFields();
      for (int i = 0; i < NREQ; i++) begin
         addrArr[i] = 7'($urandom);
         opArr[i]   = 1'($urandom);
         dinArr[i]  = 8'($urandom);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rrPtr = 0;
   endtask

   // One complete transaction with the bench acting as the I2C master.
   task automatic doTxn(input logic [NREQ-1:0] mask, input int busyCycles, input int doneDelay,
                        input logic [7:0] slaveData, input logic slaveNack,
                        input bit spurious, input bit dropReq);
      int w;
      w = pickWinner(mask, rrPtr);
      applyStimulus(mask);
      m_done = spurious;
      m_busy = (busyCycles > 0);
      for (int k = 0; k < busyCycles; k++) begin
         @(negedge clk);
         checkOutput("busy_gnt", 32'(gnt), 32'd0);
      end
      m_busy = 1'b0;
      @(negedge clk);
      checkOutput("gnt", 32'(gnt), 32'(1 << w));
      checkOutput("m_newd_early", 32'(m_newd), 32'd0);
      checkOutput("m_addr", 32'(m_addr), 32'(addrArr[w]));
      checkOutput("m_op", 32'(m_op), 32'(opArr[w]));
      checkOutput("m_din", 32'(m_din), 32'(dinArr[w]));
      if (dropReq) req = '0;
      @(negedge clk);
      m_done = 1'b0;
      checkOutput("m_newd", 32'(m_newd), 32'd1);
      m_busy = 1'b1;
      for (int k = 0; k < doneDelay; k++) begin
         @(negedge clk);
         checkOutput("m_newd_single", 32'(m_newd), 32'd0);
         checkOutput("rsp_early", 32'(rsp_valid), 32'd0);
      end
      m_done    = 1'b1;
      m_dout    = slaveData;
      m_ack_err = slaveNack;
      @(negedge clk);
      m_done    = 1'b0;
      m_busy    = 1'b0;
      m_dout    = 8'($urandom);
      m_ack_err = 1'b0;
      checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_id", 32'(rsp_id), 32'(w));
      checkOutput("rsp_dout", 32'(rsp_dout), 32'(opArr[w] ? slaveData : 8'h00));
      checkOutput("rsp_ack_err", 32'(rsp_ack_err), 32'(slaveNack));
      checkOutput("rsp_timeout", 32'(rsp_timeout), 32'd0);
      checkOutput("m_addr_hold", 32'(m_addr), 32'(addrArr[w]));
      rrPtr = (w + 1) % NREQ;
      @(negedge clk);
      checkOutput("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      checkOutput("gnt_release", 32'(gnt), 32'd0);
   endtask

   initial begin
      int w;
      int cyc;
      logic [NREQ-1:0] mask;

      rst = 1'b1; req = '0; req_addr = '0; req_op = '0; req_din = '0;
      m_busy = 1'b0; m_done = 1'b0; m_dout = '0; m_ack_err = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         addrArr[i] = '0; opArr[i] = 1'b0; dinArr[i] = '0;
      end
      repeat (3) @(negedge clk);
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("rst_rsp_dout", 32'(rsp_dout), 32'd0);
      checkOutput("rst_rsp_ack_err", 32'(rsp_ack_err), 32'd0);
      checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      checkOutput("rst_m_newd", 32'(m_newd), 32'd0);
      checkOutput("rst_m_addr", 32'(m_addr), 32'd0);
      checkOutput("rst_m_op", 32'(m_op), 32'd0);
      checkOutput("rst_m_din", 32'(m_din), 32'd0);
      rst = 1'b0;

      // Stray completion while idle must not produce a response.
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      @(negedge clk);
      checkOutput("stray_done", 32'(rsp_valid), 32'd0);

      // Busy guard: requester 0 waits while the master reports busy.
      randomFields();
      doTxn(4'b0001, 4, 2, 8'h11, 1'b0, 1'b0, 1'b0);

      // Single write from requester 2.
      randomFields();
      addrArr[2] = 7'h50; opArr[2] = 1'b0; dinArr[2] = 8'hA5;
      doTxn(4'b0100, 0, 3, 8'hEE, 1'b0, 1'b0, 1'b0);

      // Single read from requester 1.
      randomFields();
      addrArr[1] = 7'h3C; opArr[1] = 1'b1;
      doTxn(4'b0010, 0, 2, 8'h5A, 1'b0, 1'b0, 1'b0);

      // Contention after reset: all four held, grants rotate 0,1,2,3,0.
      req = '0;
      doReset();
      randomFields();
      for (int t = 0; t < 5; t++) doTxn(4'b1111, 0, 1, 8'(t * 17 + 3), 1'b0, 1'b0, 1'b0);

      // Reset while waiting for the master: no response, pointer back to 0.
      randomFields();
      applyStimulus(4'b1111);
      w = pickWinner(4'b1111, rrPtr);
      @(negedge clk);
      checkOutput("pre_rst_gnt", 32'(gnt), 32'(1 << w));
      @(negedge clk);
      m_busy = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rrPtr = 0;
      checkOutput("abort_gnt", 32'(gnt), 32'd0);
      checkOutput("abort_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("abort_m_newd", 32'(m_newd), 32'd0);
      checkOutput("abort_m_addr", 32'(m_addr), 32'd0);
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("abort_busy_gnt", 32'(gnt), 32'd0);
      doTxn(4'b1111, 2, 1, 8'h77, 1'b1, 1'b0, 1'b0);

      // Randomized traffic against the rotating-priority model.
      for (int t = 0; t < 40; t++) begin
         randomFields();
         mask = 4'($urandom_range(1, 15));
         doTxn(mask, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
               int'($urandom_range(0, 6)), 8'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 4) == 0));
      end

`ifdef I2C_ARBITER_TIMEOUT_EN
      // Master never completes: watchdog forces a timed-out response.
      randomFields();
      mask = 4'b1000;
      opArr[3] = 1'b1;
      applyStimulus(mask);
      w = pickWinner(mask, rrPtr);
      @(negedge clk);
      checkOutput("to_gnt", 32'(gnt), 32'(1 << w));
      @(negedge clk);
      checkOutput("to_m_newd", 32'(m_newd), 32'd1);
      m_busy = 1'b1;
      m_dout = 8'hC3;
      cyc = 0;
      while (!rsp_valid && cyc < TIMEOUT + 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("to_latency", 32'(cyc), 32'(TIMEOUT));
      checkOutput("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
      checkOutput("to_rsp_ack_err", 32'(rsp_ack_err), 32'd1);
      checkOutput("to_rsp_dout", 32'(rsp_dout), 32'd0);
      checkOutput("to_rsp_id", 32'(rsp_id), 32'(w));
      rrPtr = (w + 1) % NREQ;
      m_busy = 1'b0;
      @(negedge clk);
      checkOutput("to_rsp_one_cycle", 32'(rsp_valid), 32'd0);
      checkOutput("to_gnt_release", 32'(gnt), 32'd0);
`endif

      req = '0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
